// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: FETCH/DECODE/EXECUTE/UPDATE with run/halt/step,
// RAM wait-state stretching, memory-timeout fault and retired-instruction count.
module phase_sequencer #(
  parameter int unsigned WAIT_FETCH = 0,
  parameter int unsigned WAIT_EXEC  = 0,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_rdy,
  input  logic             mem_acc,
  input  logic             clr_fault,
  output logic [2:0]       phase,
  output logic             halted,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_IDLE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] WF = 4'(WAIT_FETCH);
  localparam logic [3:0] WE = 4'(WAIT_EXEC);
  localparam logic [7:0] TO = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [7:0] tcnt, tcnt_nx;
  logic       acc, acc_nx;
  logic       step_mode, step_mode_nx;
  logic       step_q;
  logic       step_rise;
  logic       retire;
  logic [2:0] phase_nx;

  assign step_rise = step & ~step_q;

  always_comb begin
    state_nx     = state;
    wcnt_nx      = wcnt;
    tcnt_nx      = tcnt;
    acc_nx       = acc;
    step_mode_nx = step_mode;
    retire       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!halt_req) begin
          if (run) begin
            state_nx     = S_FETCH;
            step_mode_nx = 1'b0;
          end else if (step_rise) begin
            state_nx     = S_FETCH;
            step_mode_nx = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (wcnt != 4'd0)      wcnt_nx  = wcnt - 4'd1;
        else if (mem_rdy)      state_nx = S_DECODE;
        else if (tcnt == TO)   state_nx = S_FAULT;
        else                   tcnt_nx  = tcnt + 8'd1;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        // Non-memory instructions never wait on the RAM
        if (!acc)              state_nx = S_UPDATE;
        else if (wcnt != 4'd0) wcnt_nx  = wcnt - 4'd1;
        else if (mem_rdy)      state_nx = S_UPDATE;
        else if (tcnt == TO)   state_nx = S_FAULT;
        else                   tcnt_nx  = tcnt + 8'd1;
      end
      S_UPDATE: begin
        retire = 1'b1;
        if (step_mode || halt_req || !run) state_nx = S_IDLE;
        else                               state_nx = S_FETCH;
      end
      S_FAULT: begin
        if (clr_fault) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Per-phase bookkeeping is (re)loaded on every state entry
    if (state_nx != state) begin
      tcnt_nx = 8'd0;
      if (state_nx == S_FETCH) wcnt_nx = WF;
      if (state_nx == S_EXEC) begin
        acc_nx  = mem_acc;
        wcnt_nx = mem_acc ? WE : 4'd0;
      end
      if (state_nx == S_IDLE) step_mode_nx = 1'b0;
    end

    phase_nx = (state_nx == S_FAULT) ? 3'd4 : state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      tcnt      <= 8'd0;
      acc       <= 1'b0;
      step_mode <= 1'b0;
      step_q    <= 1'b0;
      instr_cnt <= '0;
      phase     <= 3'd4;
      halted    <= 1'b1;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      tcnt      <= tcnt_nx;
      acc       <= acc_nx;
      step_mode <= step_mode_nx;
      step_q    <= step;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      phase     <= phase_nx;
      halted    <= (state_nx == S_IDLE);
      busy      <= (state_nx == S_FETCH) || (state_nx == S_DECODE) ||
                   (state_nx == S_EXEC)  || (state_nx == S_UPDATE);
      fault     <= (state_nx == S_FAULT);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default instance and a
// wait-state / timeout / narrow-counter instance.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic [1:0] rst, run, stp, hlt, rdy, acc, clr;
  logic [2:0] ph [2];
  logic [1:0] hd, by, ft;
  logic [15:0] c0;
  logic [3:0]  c1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phase_sequencer u0 (
    .clk(clk), .reset(rst[0]), .run(run[0]), .step(stp[0]),
    .halt_req(hlt[0]), .mem_rdy(rdy[0]), .mem_acc(acc[0]),
    .clr_fault(clr[0]), .phase(ph[0]), .halted(hd[0]), .busy(by[0]),
    .fault(ft[0]), .instr_cnt(c0)
  );

  phase_sequencer #(
    .WAIT_FETCH(2), .WAIT_EXEC(1), .TIMEOUT(4), .CNT_W(4)
  ) u1 (
    .clk(clk), .reset(rst[1]), .run(run[1]), .step(stp[1]),
    .halt_req(hlt[1]), .mem_rdy(rdy[1]), .mem_acc(acc[1]),
    .clr_fault(clr[1]), .phase(ph[1]), .halted(hd[1]), .busy(by[1]),
    .fault(ft[1]), .instr_cnt(c1)
  );

  // ph: 0..4 = PHASE value, 5 = FAULT state (PHASE reads 4)
  typedef struct {
    bit r, s, h, m, a, c;
    int ph;
    int cnt;
  } vec_t;

  vec_t t0[$];
  vec_t t1[$];

  function automatic vec_t mk(bit r, s, h, m, a, c, int p, int n);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.m = m; v.a = a; v.c = c;
    v.ph = p; v.cnt = n;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic drive(int u, vec_t v);
    run[u] = v.r; stp[u] = v.s; hlt[u] = v.h;
    rdy[u] = v.m; acc[u] = v.a; clr[u] = v.c;
  endtask

  task automatic check_unit(int u, int p, int n, string tag);
    logic [31:0] cnt;
    cnt = (u == 0) ? 32'(c0) : 32'(c1);
    chk({tag, " phase"},  32'(ph[u]), (p == 5) ? 32'd4 : 32'(p));
    chk({tag, " halted"}, 32'(hd[u]), 32'(p == 4));
    chk({tag, " busy"},   32'(by[u]), 32'(p < 4));
    chk({tag, " fault"},  32'(ft[u]), 32'(p == 5));
    chk({tag, " cnt"},    cnt, 32'(n));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 2'b11; run = '0; stp = '0; hlt = '0;
    rdy = '0; acc = '0; clr = '0;

    // u0: free run, halt, step, run-beats-step, run drop mid-instruction
    t0.push_back(mk(1,0,0,1,0,0,0,0));
    t0.push_back(mk(1,0,0,1,0,0,1,0));
    t0.push_back(mk(1,0,0,1,0,0,2,0));
    t0.push_back(mk(1,0,0,1,0,0,3,0));
    t0.push_back(mk(1,0,0,1,0,0,0,1));
    t0.push_back(mk(1,0,0,1,0,0,1,1));
    t0.push_back(mk(1,0,0,1,0,0,2,1));
    t0.push_back(mk(1,0,0,1,0,0,3,1));
    t0.push_back(mk(1,0,0,1,0,0,0,2));
    t0.push_back(mk(1,0,0,1,0,0,1,2));
    t0.push_back(mk(1,0,0,1,0,0,2,2));
    t0.push_back(mk(1,0,0,1,0,0,3,2));
    t0.push_back(mk(1,0,0,1,0,0,0,3));
    t0.push_back(mk(1,0,0,1,0,0,1,3));
    t0.push_back(mk(1,0,1,1,0,0,2,3));
    t0.push_back(mk(1,0,1,1,0,0,3,3));
    t0.push_back(mk(1,0,1,1,0,0,4,4));
    t0.push_back(mk(1,0,1,1,0,0,4,4));
    t0.push_back(mk(0,1,1,1,0,0,4,4));
    t0.push_back(mk(0,1,0,1,0,0,4,4));
    t0.push_back(mk(0,0,0,1,0,0,4,4));
    t0.push_back(mk(0,1,0,1,0,0,0,4));
    t0.push_back(mk(0,0,0,1,0,0,1,4));
    t0.push_back(mk(0,1,0,1,0,0,2,4));
    t0.push_back(mk(0,0,0,1,0,0,3,4));
    t0.push_back(mk(0,1,0,1,0,0,4,5));
    t0.push_back(mk(0,1,0,1,0,0,4,5));
    t0.push_back(mk(0,0,0,1,0,0,4,5));
    t0.push_back(mk(1,1,0,1,0,0,0,5));
    t0.push_back(mk(1,0,0,1,0,0,1,5));
    t0.push_back(mk(1,0,0,1,0,0,2,5));
    t0.push_back(mk(1,0,0,0,0,0,3,5));
    t0.push_back(mk(1,0,0,1,0,0,0,6));
    t0.push_back(mk(0,0,0,1,0,0,1,6));
    t0.push_back(mk(0,0,0,1,0,0,2,6));
    t0.push_back(mk(0,0,0,1,0,0,3,6));
    t0.push_back(mk(0,0,0,1,0,0,4,7));

    // u1: WAIT_FETCH=2, WAIT_EXEC=1, TIMEOUT=4
    t1.push_back(mk(1,0,0,0,0,0,0,0));
    t1.push_back(mk(1,0,0,0,0,0,0,0));
    t1.push_back(mk(1,0,0,0,0,0,0,0));
    t1.push_back(mk(1,0,0,0,0,0,0,0));
    t1.push_back(mk(1,0,0,0,0,0,0,0));
    t1.push_back(mk(1,0,0,1,0,0,1,0));
    t1.push_back(mk(1,0,0,1,1,0,2,0));
    t1.push_back(mk(1,0,0,1,0,0,2,0));
    t1.push_back(mk(1,0,0,1,0,0,3,0));
    t1.push_back(mk(1,0,0,1,0,0,0,1));
    t1.push_back(mk(1,0,0,1,0,0,0,1));
    t1.push_back(mk(1,0,0,1,0,0,0,1));
    t1.push_back(mk(1,0,0,1,0,0,1,1));
    t1.push_back(mk(1,0,0,1,1,0,2,1));
    t1.push_back(mk(1,0,0,0,0,0,2,1));
    t1.push_back(mk(1,0,0,0,0,0,2,1));
    t1.push_back(mk(0,0,0,1,0,0,3,1));
    t1.push_back(mk(0,0,0,1,0,0,4,2));
    t1.push_back(mk(1,0,0,0,0,0,0,2));
    t1.push_back(mk(1,0,0,0,0,0,0,2));
    t1.push_back(mk(1,0,0,0,0,0,0,2));
    t1.push_back(mk(0,0,0,0,0,0,0,2));
    t1.push_back(mk(0,0,0,0,0,0,0,2));
    t1.push_back(mk(0,0,0,0,0,0,0,2));
    t1.push_back(mk(0,0,0,0,0,0,5,2));
    t1.push_back(mk(1,1,1,0,0,0,5,2));
    t1.push_back(mk(0,0,0,0,0,1,4,2));
    t1.push_back(mk(0,0,0,1,0,0,4,2));
    t1.push_back(mk(1,0,0,1,0,0,0,2));
    t1.push_back(mk(1,0,0,1,0,0,0,2));
    t1.push_back(mk(1,0,0,1,0,0,0,2));
    t1.push_back(mk(1,0,0,1,0,0,1,2));
    t1.push_back(mk(0,0,0,1,1,0,2,2));
    t1.push_back(mk(0,0,0,0,0,0,2,2));
    t1.push_back(mk(0,0,0,0,0,0,2,2));
    t1.push_back(mk(0,0,0,0,0,0,2,2));
    t1.push_back(mk(0,0,0,0,0,0,2,2));
    t1.push_back(mk(0,0,0,0,0,0,5,2));
    t1.push_back(mk(0,0,0,0,0,1,4,2));

    tick();
    tick();
    check_unit(0, 4, 0, "rst u0");
    check_unit(1, 4, 0, "rst u1");
    rst = 2'b00;

    foreach (t0[i]) begin
      drive(0, t0[i]);
      tick();
      check_unit(0, t0[i].ph, t0[i].cnt, $sformatf("u0 v%0d", i + 1));
    end
    drive(0, mk(0,0,0,1,0,0,4,0));

    foreach (t1[i]) begin
      drive(1, t1[i]);
      tick();
      check_unit(1, t1[i].ph, t1[i].cnt, $sformatf("u1 v%0d", i + 1));
    end
    drive(1, mk(0,0,0,1,0,0,4,0));

    // Async reset in the middle of EXECUTE
    run[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("u0 pre-reset phase", 32'(ph[0]), 32'd2);
    run[0] = 1'b0;
    #2 rst[0] = 1'b1;
    #1 check_unit(0, 4, 0, "u0 async rst");
    @(posedge clk);
    #1 rst[0] = 1'b0;
    tick();
    check_unit(0, 4, 0, "u0 post rst");

    // 4-bit counter wrap: 6 cycles per instruction at these waits
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    drive(1, mk(1,0,0,1,0,0,0,0));
    tick();
    for (int k = 1; k <= 16; k++) begin
      for (int j = 0; j < 6; j++) tick();
      chk($sformatf("u1 wrap%0d phase", k), 32'(ph[1]), 32'd0);
      chk($sformatf("u1 wrap%0d cnt", k), 32'(c1), 32'(k % 16));
    end
    run[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
